// File: rtl/iir_arb_pkg.sv
// iir_arb_pkg: shared state encoding, channel-tag width helper and timer width for the IIR channel arbiter.
package iir_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;
   localparam int TMR_W = 16;
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/iir_rr_pick.sv
// iir_rr_pick: combinational circular priority picker, first set request at or after ptr.
module iir_rr_pick
   import iir_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W = ch_w(NUM_CH)
)(
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   grant,
   output logic              any_req
);
   logic [CH_W-1:0] idx;
   assign any_req = |req;
   // Walk offsets from farthest to nearest so the nearest request at or after ptr wins.
   always_comb begin
      grant = '0;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = CH_W'((32'(ptr) + 32'(i)) % NUM_CH);
         if (req[idx]) grant = idx;
      end
   end
endmodule

// File: rtl/iir_ch_arbiter.sv
// iir_ch_arbiter: round-robin time-sharing of one IIR core across NUM_CH tagged sample streams.
// Define IIR_ARB_STATS_EN to build per-channel completed-sample counters readable via stat_sel.
module iir_ch_arbiter
   import iir_arb_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 32,
   parameter int CORE_LAT = 5,
   parameter int TIMEOUT  = 16,
   localparam int CH_W    = ch_w(NUM_CH)
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        s_valid,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   output logic [NUM_CH-1:0]        s_ready,
   output logic                     core_in_valid,
   output logic [DATA_W-1:0]        core_in_data,
   output logic [CH_W-1:0]          core_in_ch,
   input  logic                     core_out_valid,
   input  logic [DATA_W-1:0]        core_out_data,
   output logic                     m_valid,
   output logic [DATA_W-1:0]        m_data,
   output logic [CH_W-1:0]          m_ch,
   input  logic                     m_ready,
   output logic                     busy,
   output logic                     err,
   input  logic [CH_W-1:0]          stat_sel,
   output logic [15:0]              stat_cnt
);
   // A misconfigured timeout is clamped so it never fires before a healthy core answers.
   localparam int TO_LIM = (TIMEOUT > CORE_LAT) ? TIMEOUT : CORE_LAT + 1;
   state_t state, state_n;
   logic [CH_W-1:0] rr_ptr, grant, pick;
   logic any_req, tmo;
   logic [TMR_W-1:0] timer;
   logic [DATA_W-1:0] ch_data [NUM_CH];
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_data[i] = s_data[i*DATA_W +: DATA_W];
   end
   iir_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .req(s_valid),
      .ptr(rr_ptr),
      .grant(pick),
      .any_req(any_req)
   );
   assign tmo = timer == TMR_W'(TO_LIM - 1);
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  state_n = any_req ? ISSUE : IDLE;
         ISSUE: state_n = WAIT;
         WAIT:  state_n = (core_out_valid || tmo) ? OUT : WAIT;
         OUT:   state_n = m_ready ? IDLE : OUT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant <= '0;
         timer <= '0;
         err <= 1'b0;
         s_ready <= '0;
         core_in_valid <= 1'b0;
         core_in_data <= '0;
         core_in_ch <= '0;
         m_valid <= 1'b0;
         m_data <= '0;
         m_ch <= '0;
      end else begin
         state <= state_n;
         core_in_valid <= state_n == ISSUE;
         s_ready <= (state_n == ISSUE) ? NUM_CH'(1) << pick : '0;
         core_in_data <= (state_n == ISSUE) ? ch_data[pick] : '0;
         core_in_ch <= (state_n == ISSUE) ? pick : '0;
         m_valid <= state_n == OUT;
         timer <= (state == WAIT) ? timer + 1'b1 : '0;
         if (state == IDLE) grant <= pick;
         if (state == ISSUE) rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
         // A timed-out slot still produces a zero result so the channel is not starved.
         if (state == WAIT && state_n == OUT) begin
            m_data <= core_out_valid ? core_out_data : '0;
            m_ch <= grant;
            err <= err | ~core_out_valid;
         end
      end
   end
`ifdef IIR_ARB_STATS_EN
   logic [15:0] cnt [NUM_CH];
   always_ff @(posedge clk) begin
      if (reset) for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      else if (m_valid && m_ready) cnt[m_ch] <= cnt[m_ch] + 16'd1;
   end
   assign stat_cnt = (32'(stat_sel) < NUM_CH) ? cnt[stat_sel] : '0;
`else
   logic unused_stat;
   assign unused_stat = ^stat_sel;
   assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_iir_ch_arbiter.sv
// tb_iir_ch_arbiter: directed and randomized checks of the channel arbiter against a behavioural model.
module tb_iir_ch_arbiter;
   localparam int N = 4, W = 32, LAT = 5, TO = 16, CW = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] s_valid = '0;
   logic [N-1:0] s_ready;
   logic [N*W-1:0] s_data;
   logic core_in_valid;
   logic [W-1:0] core_in_data;
   logic [CW-1:0] core_in_ch;
   logic core_out_valid = 1'b0;
   logic [W-1:0] core_out_data = '0;
   logic m_valid;
   logic [W-1:0] m_data;
   logic [CW-1:0] m_ch;
   logic m_ready = 1'b1;
   logic busy, err;
   logic [CW-1:0] stat_sel = '0;
   logic [15:0] stat_cnt;
   logic [W-1:0] samp [N];
   int n_assert = 0, n_fail = 0, ptr_m = 0;
   int cnt_m [N];
   logic err_m = 1'b0;

   always #5 clk = ~clk;
   for (genvar i = 0; i < N; i++) begin : g_pack
      assign s_data[i*W +: W] = samp[i];
   end

   iir_ch_arbiter #(.NUM_CH(N), .DATA_W(W), .CORE_LAT(LAT), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_ch(core_in_ch),
      .core_out_valid(core_out_valid), .core_out_data(core_out_data),
      .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch), .m_ready(m_ready),
      .busy(busy), .err(err), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Spec rule: first pending channel at or after the round-robin pointer, searching upward circularly.
   function automatic int pick_m(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
      return 0;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ":s_ready"}, 32'(s_ready), 0);
      check({tag, ":core_in_valid"}, 32'(core_in_valid), 0);
      check({tag, ":core_in_data"}, core_in_data, 0);
      check({tag, ":core_in_ch"}, 32'(core_in_ch), 0);
      check({tag, ":m_valid"}, 32'(m_valid), 0);
      check({tag, ":m_data"}, m_data, 0);
      check({tag, ":m_ch"}, 32'(m_ch), 0);
      check({tag, ":busy"}, 32'(busy), 0);
      check({tag, ":err"}, 32'(err), 0);
   endtask

   task automatic do_reset(input string tag);
      s_valid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ptr_m = 0;
      err_m = 1'b0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
      check_idle(tag);
   endtask

   // One full transaction; lat=0 means the core never answers, stall holds m_ready low that many cycles.
   task automatic txn(input logic [N-1:0] v, input int lat, input int stall, input string tag);
      int g, cyc;
      logic [W-1:0] x;
      g = pick_m(v);
      s_valid = v;
      m_ready = (stall == 0);
      cyc = 0;
      do begin tick(); cyc++; end while (!core_in_valid && cyc < 4);
      check({tag, ":issue"}, 32'(core_in_valid), 1);
      check({tag, ":ch"}, 32'(core_in_ch), 32'(g));
      check({tag, ":s_ready"}, 32'(s_ready), 32'(1) << g);
      check({tag, ":in_data"}, core_in_data, samp[g]);
      x = samp[g];
      samp[g] = $urandom;
      ptr_m = (g + 1) % N;
      if (lat == 0) begin
         repeat (TO) tick();
         check({tag, ":pre_tmo_valid"}, 32'(m_valid), 0);
         check({tag, ":pre_tmo_err"}, 32'(err), 32'(err_m));
         tick();
         err_m = 1'b1;
         x = '0;
      end else begin
         repeat (lat - 1) tick();
         core_out_valid = 1'b1;
         core_out_data = x << 1;
         tick();
         core_out_valid = 1'b0;
         x = x << 1;
      end
      check({tag, ":m_valid"}, 32'(m_valid), 1);
      check({tag, ":m_data"}, m_data, x);
      check({tag, ":m_ch"}, 32'(m_ch), 32'(g));
      check({tag, ":err"}, 32'(err), 32'(err_m));
      for (int k = 0; k < stall; k++) begin
         tick();
         check({tag, ":hold_valid"}, 32'(m_valid), 1);
         check({tag, ":hold_data"}, m_data, x);
         check({tag, ":hold_ch"}, 32'(m_ch), 32'(g));
         check({tag, ":hold_busy"}, 32'(busy), 1);
         check({tag, ":hold_no_issue"}, 32'(core_in_valid), 0);
      end
      m_ready = 1'b1;
      tick();
      check({tag, ":drop_valid"}, 32'(m_valid), 0);
      check({tag, ":idle"}, 32'(busy), 0);
      check({tag, ":err_keep"}, 32'(err), 32'(err_m));
      cnt_m[g]++;
   endtask

   initial begin
      int cyc;
      logic [31:0] exp_cnt;
      for (int i = 0; i < N; i++) samp[i] = $urandom;
      tick();
      do_reset("reset");
      check("reset:stat_cnt", 32'(stat_cnt), 0);

      samp[2] = 32'sd100;
      txn(4'b0100, LAT, 0, "single");
      check("single:result", m_data, 32'sd200);

      do_reset("rr_reset");
      for (int t = 0; t < 8; t++) begin
         check("rr:order", 32'(pick_m(4'b1111)), 32'(t % N));
         txn(4'b1111, $urandom_range(2, 12), 0, "rr");
      end

      for (int t = 0; t < 20; t++) txn(N'($urandom_range(1, 15)), $urandom_range(2, 14), 0, "rand");

      s_valid = '0;
      core_out_valid = 1'b1;
      core_out_data = 32'hdead_beef;
      tick();
      core_out_valid = 1'b0;
      tick();
      check("stray:m_valid", 32'(m_valid), 0);
      check("stray:busy", 32'(busy), 0);

      txn(4'b1000, LAT, 10, "bp");
      txn(4'b0001, 0, 0, "tmo");
      txn(4'b0100, $urandom_range(2, 12), 0, "after_tmo");

      s_valid = 4'b0110;
      cyc = 0;
      do begin tick(); cyc++; end while (!core_in_valid && cyc < 4);
      check("rstw:issue", 32'(core_in_valid), 1);
      repeat (2) tick();
      check("rstw:busy", 32'(busy), 1);
      do_reset("rstw");
      txn(4'b1111, LAT, 0, "post_rst");

      do_reset("stats_reset");
      for (int t = 0; t < 3; t++) txn(4'b0010, $urandom_range(2, 12), 0, "stats");
      s_valid = '0;
      for (int i = 0; i < N; i++) begin
         stat_sel = CW'(i);
         #1;
`ifdef IIR_ARB_STATS_EN
         exp_cnt = 32'(cnt_m[i]);
`else
         exp_cnt = 0;
`endif
         check("stats:cnt", 32'(stat_cnt), exp_cnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/iir_ch_arbiter.md
Name: iir_ch_arbiter

Overview:
Time-shares one IIR filter core between NUM_CH sample streams, for example a stereo or quad audio path.
- Round-robin arbitration picks one pending channel sample.
- The sample is issued to the core tagged with its channel index, so the core selects that channel's delay-line state.
- The block waits for the core result and presents it on a tagged valid/ready output.
- Sits between the per-channel sample sources and IIR_main-style core instances.

Parameters:
NUM_CH, 4, number of requesting channels (2..16).
DATA_W, 32, signed sample width, two's complement.
CORE_LAT, 5, nominal core latency in cycles, from core_in_valid to core_out_valid.
TIMEOUT, 16, maximum cycles waited for core_out_valid before flagging an error; must be greater than CORE_LAT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
s_valid  in  NUM_CH  per-channel sample pending.
s_data  in  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
s_ready  out  NUM_CH  one-hot, one-cycle acceptance strobe.
core_in_valid  out  1  issue strobe to the core.
core_in_data  out  DATA_W  sample issued to the core.
core_in_ch  out  CH_W  channel tag; CH_W = max(1, clog2(NUM_CH)).
core_out_valid  in  1  core result strobe.
core_out_data  in  DATA_W  core result.
m_valid  out  1  result available.
m_data  out  DATA_W  filtered sample.
m_ch  out  CH_W  channel of m_data.
m_ready  in  1  downstream accept.
busy  out  1  high whenever state is not IDLE.
err  out  1  sticky core-timeout flag.
stat_sel  in  CH_W  statistics channel select.
stat_cnt  out  16  completed-sample count for stat_sel.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, timer=0, err=0. All outputs are 0: s_ready, core_in_*, m_*, busy, err. The reset takes effect on the next edge, in any state; an in-flight core result is discarded.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: if any s_valid is high, pick grant = the first set bit at or after rr_ptr, searching circularly upward. Register grant and go to ISSUE. If none is set, stay in IDLE.
- ISSUE (exactly 1 cycle): assert core_in_valid=1, core_in_data=s_data[grant], core_in_ch=grant and s_ready[grant]=1, all registered outputs. Set rr_ptr = (grant+1) mod NUM_CH. Clear timer. Go to WAIT.
- Source rule: a source must hold s_valid and s_data stable until it sees s_ready.
- WAIT: timer increments every cycle.
  - On core_out_valid: capture core_out_data into m_data, set m_ch=grant, m_valid=1, go to OUT.
  - If timer reaches TIMEOUT-1 without core_out_valid: set err=1, drive m_data=0 with m_valid=1 (the slot is not lost), go to OUT.
- A core_out_valid outside WAIT is ignored.
- OUT: hold m_valid, m_data and m_ch stable until m_valid&&m_ready.
  - On that handshake, m_valid drops next cycle and state goes to IDLE.
  - The next grant is evaluated in IDLE, so minimum spacing between issues is CORE_LAT+3 cycles.
- Fairness: every continuously valid channel is served within NUM_CH transactions.
- Simultaneous requests are resolved purely by rr_ptr order.
- A channel that deasserts s_valid before its grant is simply skipped.
- err clears only on reset.
- With NUM_CH=1, grant is always 0.

Optional Feature:
IIR_ARB_STATS_EN
- Defined: one 16-bit wrapping counter per channel, incremented on each m_valid&&m_ready handshake for channel m_ch. The counters clear on reset. stat_cnt = counter[stat_sel], combinational read.
- Undefined: no counters are built and stat_cnt is tied to 0. Ports are unchanged.

Decomposition:
- Package iir_arb_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, OUT=3);
  - the CH_W helper function;
  - the timer width constant.
- Sub-module iir_rr_pick: combinational circular priority picker. Inputs are req[NUM_CH] and ptr; outputs are the grant index and any_req. It is instantiated once.

Test Plan:
- Single request: reset, then s_valid=4'b0100 with s_data[2]=32'sd100, and the core model echoes x2 after 5 cycles. Expect core_in_ch=2 one cycle after the IDLE grant, s_ready=4'b0100 for one cycle, then m_valid with m_data=200 and m_ch=2.
- Round robin: hold all four valid for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3.
- Backpressure: hold m_ready=0 for 10 cycles. Expect m_valid, m_data and m_ch stable, no new core_in_valid, and busy=1 throughout.
- Timeout: the core never responds. Expect err=1 at timer=15, m_valid=1 with m_data=0, and err still 1 after the handshake.
- Reset mid-WAIT: assert reset for 1 cycle. Expect all outputs 0 next cycle and rr_ptr=0, so a following all-valid request is granted to channel 0.
- Stats: with IIR_ARB_STATS_EN defined, run 3 transactions on channel 1. Expect stat_sel=1 gives stat_cnt=3 and stat_sel=0 gives 0. With the macro undefined, stat_cnt is always 0.
